pu_play_driver: RTL

Parametrised on-board stimulus/readback driver for a single processing unit (PU) under test, such as pu_div or pu_mul. A Moore FSM issues two operand writes, waits a configurable latency, reads the result and captures it. It repeats continuously at full or prescaled speed and shows the top result bits on LEDs. The block sits between the board top (PLL, DIP switches, keys) and the PU's wr/sel/oe/data/attr interface.

---
 rtl/play_pkg.sv | 17 +
 rtl/play_prescaler.sv | 28 ++
 rtl/pu_play_driver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/play_pkg.sv
// Shared definitions for the PU play driver: FSM state encoding, error counter
// width and default attribute index flagging an invalid result.
package play_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_A = 3'd1,
    S_WR_B = 3'd2,
    S_WAIT = 3'd3,
    S_RD   = 3'd4,
    S_GAP  = 3'd5
  } play_state_e;

  localparam int unsigned ERR_WIDTH       = 16;
  localparam int unsigned INVALID_DEFAULT = 1;

endpackage

// File: rtl/play_prescaler.sv
// Free-running gap prescaler: counts while enabled, held at zero while cleared,
// wrap_o flags the last count of a 2^STEP_DIV_WIDTH cycle window.
module play_prescaler #(
  parameter int unsigned STEP_DIV_WIDTH = 20
) (
  input  logic clk,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  logic [STEP_DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign wrap_o = en_i && !clr_i && (cnt_q == '1);

endmodule

// File: rtl/pu_play_driver.sv
// Stimulus/readback driver for one PU under test: write A, write B, wait,
// read and capture, repeat. Optional invalid-result checker: PLAY_CHECK_EN.
module pu_play_driver
  import play_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ATTR_WIDTH     = 4,
  parameter int unsigned INVALID        = INVALID_DEFAULT,
  parameter int unsigned LATENCY        = 8,
  parameter int unsigned STEP_DIV_WIDTH = 20,
  parameter int unsigned LED_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  mode_int,
  input  logic                  speed,
  input  logic                  sel_res,
  output logic                  pu_signal_wr,
  output logic                  pu_signal_sel,
  output logic [DATA_WIDTH-1:0] pu_data_in,
  output logic [ATTR_WIDTH-1:0] pu_attr_in,
  output logic                  pu_res_select,
  output logic                  pu_signal_oe,
  input  logic [DATA_WIDTH-1:0] pu_data_out,
  input  logic [ATTR_WIDTH-1:0] pu_attr_out,
  output logic                  busy,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [ATTR_WIDTH-1:0] result_attr,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [LED_WIDTH-1:0]  led
);

  if (INVALID >= ATTR_WIDTH || LED_WIDTH > DATA_WIDTH || LED_WIDTH == 0) begin : g_bad_cfg
    $error("pu_play_driver: INVALID or LED_WIDTH out of range");
  end

  localparam int unsigned WAIT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned WAIT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

  play_state_e             state_q, state_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]   seq_q;
  logic                    sel_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   res_data_q;
  logic [ATTR_WIDTH-1:0]   res_attr_q;
  logic                    gap_wrap;

  play_prescaler #(
    .STEP_DIV_WIDTH(STEP_DIV_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .RST    (RST),
    .clr_i  (state_q != S_GAP),
    .en_i   (state_q == S_GAP),
    .wrap_o (gap_wrap)
  );

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    pu_signal_wr  = 1'b0;
    pu_signal_sel = 1'b0;
    pu_signal_oe  = 1'b0;
    pu_data_in    = '0;
    case (state_q)
      S_IDLE: if (mode_int) state_d = S_WR_A;
      S_WR_A: begin
        pu_signal_wr = 1'b1;
        pu_data_in   = seq_q;
        state_d      = S_WR_B;
      end
      S_WR_B: begin
        pu_signal_wr  = 1'b1;
        pu_signal_sel = 1'b1;
        pu_data_in    = seq_q | DATA_WIDTH'(1);
        state_d       = (LATENCY == 0) ? S_RD : S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_W'(WAIT_LAST)) state_d = S_RD;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_RD: begin
        pu_signal_oe = 1'b1;
        if (!mode_int)  state_d = S_IDLE;
        else if (speed) state_d = S_WR_A;
        else            state_d = S_GAP;
      end
      S_GAP: if (gap_wrap) state_d = mode_int ? S_WR_A : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      seq_q      <= '0;
      sel_q      <= 1'b0;
      valid_q    <= 1'b0;
      res_data_q <= '0;
      res_attr_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      valid_q    <= (state_q == S_RD);
      // Latch the selector on entry so it is stable for the whole transaction.
      if (state_d == S_WR_A) sel_q <= sel_res;
      if (state_q == S_RD) begin
        res_data_q <= pu_data_out;
        res_attr_q <= pu_attr_out;
        seq_q      <= seq_q + 1'b1;
      end
    end
  end

`ifdef PLAY_CHECK_EN
  logic [ERR_WIDTH-1:0] err_q;

  always_ff @(posedge clk) begin
    if (RST) err_q <= '0;
    else if (state_q == S_RD && pu_attr_out[INVALID] && err_q != '1) err_q <= err_q + 1'b1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  always_comb begin
    led = res_data_q[DATA_WIDTH-1 -: LED_WIDTH];
`ifdef PLAY_CHECK_EN
    led[LED_WIDTH-1] = (err_q != '0);
`endif
  end

  assign pu_attr_in    = '0;
  assign pu_res_select = sel_q;
  assign busy          = (state_q != S_IDLE);
  assign result_valid  = valid_q;
  assign result_data   = res_data_q;
  assign result_attr   = res_attr_q;

endmodule
